// File: rtl/chimera_clu_iso_ctrl.sv
// Purpose : per-cluster isolate / clock-gate / reset sequencer, one independent FSM per cluster.
// Latency : outputs are registered from the next state, so they follow the state register with no added lag.
// Backpressure: ISO_REQ and RELEASE wait on isolated_i. With CHIMERA_ISO_TIMEOUT_EN defined, the wait is bounded by TimeoutCycles.
//
// Ports:
//   clk_i            SoC clock; every register samples on its rising edge.
//   rst_i            async active-high reset. Puts every FSM in RUN with the cluster reset asserted.
//   power_down_req_i level request to isolate and clock-gate cluster i.
//   reset_req_i      single-cycle pulse requesting an isolate/reset/release cycle.
//   isolated_i       isolation acknowledge from the cluster domain.
//   isolate_o        isolation request to the cluster domain.
//   clk_en_o         cluster clock enable.
//   cluster_rst_no   cluster reset, active-low.
//   busy_o           high whenever the FSM is not in RUN.
//   timeout_o        sticky handshake-timeout flag. It is tied 0 unless CHIMERA_ISO_TIMEOUT_EN is defined.
//
// Optional feature: define CHIMERA_ISO_TIMEOUT_EN to bound the ISO_REQ/RELEASE handshakes.
module chimera_clu_iso_ctrl #(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned RstHoldCycles = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] power_down_req_i,
  input  logic [NumClusters-1:0] reset_req_i,
  input  logic [NumClusters-1:0] isolated_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_no,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] timeout_o
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    ISO_REQ  = 3'd1,
    ISOLATED = 3'd2,
    RST_HOLD = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  // The hold counter counts down to zero, so the cluster sees exactly RstHoldCycles cycles in RST_HOLD.
  localparam logic [7:0] HoldLoad = 8'(RstHoldCycles - 1);

`ifdef CHIMERA_ISO_TIMEOUT_EN
  localparam logic [15:0] HsLast = 16'(TimeoutCycles - 1);
`endif

  for (genvar g = 0; g < NumClusters; g++) begin : g_cl
    state_e     state_q, state_d;
    logic       pend_q, pend_d;
    logic [7:0] hold_q, hold_d;
    logic       iso_q, iso_d;
    logic       clk_en_q, clk_en_d;
    logic       rst_n_q, rst_n_d;
    logic       busy_q, busy_d;
`ifdef CHIMERA_ISO_TIMEOUT_EN
    logic [15:0] hs_q, hs_d;
    logic        to_q, to_d;
`endif

    always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      hold_d  = hold_q;
`ifdef CHIMERA_ISO_TIMEOUT_EN
      hs_d    = hs_q;
      to_d    = to_q;
`endif

      // The reset request is only latched before the reset has actually been applied.
      if ((state_q == RUN || state_q == ISO_REQ || state_q == ISOLATED) && reset_req_i[g]) begin
        pend_d = 1'b1;
      end

      unique case (state_q)
        RUN: begin
          if (power_down_req_i[g] || reset_req_i[g]) state_d = ISO_REQ;
        end
        ISO_REQ: begin
          // Dropping power_down_req_i here does not abort the sequence.
          // Only the acknowledge, or the timeout, moves the FSM on.
          if (isolated_i[g]) begin
            state_d = ISOLATED;
`ifdef CHIMERA_ISO_TIMEOUT_EN
          end else if (hs_q == HsLast) begin
            state_d = ISOLATED;
            to_d    = 1'b1;
          end else begin
            hs_d = hs_q + 16'd1;
`endif
          end
        end
        ISOLATED: begin
          // A reset pulse in this same cycle counts, so RST_HOLD follows immediately.
          if (pend_q || reset_req_i[g] || !power_down_req_i[g]) state_d = RST_HOLD;
        end
        RST_HOLD: begin
          if (hold_q == 8'd0) state_d = RELEASE;
          else                hold_d  = hold_q - 8'd1;
        end
        RELEASE: begin
          if (!isolated_i[g]) begin
            state_d = RUN;
`ifdef CHIMERA_ISO_TIMEOUT_EN
          end else if (hs_q == HsLast) begin
            state_d = RUN;
            to_d    = 1'b1;
          end else begin
            hs_d = hs_q + 16'd1;
`endif
          end
        end
        default: state_d = RUN;
      endcase

      // Entry actions.
      if (state_d != state_q) begin
        case (state_d)
          RST_HOLD: begin
            hold_d = HoldLoad;
            pend_d = 1'b0;
          end
`ifdef CHIMERA_ISO_TIMEOUT_EN
          ISO_REQ, RELEASE: hs_d = 16'd0;
`endif
          default: ;
        endcase
      end

      // Outputs are decoded from the next state and then registered.
      iso_d    = 1'b0;
      clk_en_d = 1'b1;
      rst_n_d  = 1'b1;
      busy_d   = (state_d != RUN);
      case (state_d)
        ISO_REQ:  iso_d = 1'b1;
        ISOLATED: begin
          iso_d    = 1'b1;
          clk_en_d = 1'b0;
        end
        RST_HOLD: begin
          iso_d   = 1'b1;
          rst_n_d = 1'b0;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q  <= RUN;
        pend_q   <= 1'b0;
        hold_q   <= 8'd0;
        iso_q    <= 1'b0;
        clk_en_q <= 1'b1;
        rst_n_q  <= 1'b0;
        busy_q   <= 1'b0;
`ifdef CHIMERA_ISO_TIMEOUT_EN
        hs_q     <= 16'd0;
        to_q     <= 1'b0;
`endif
      end else begin
        state_q  <= state_d;
        pend_q   <= pend_d;
        hold_q   <= hold_d;
        iso_q    <= iso_d;
        clk_en_q <= clk_en_d;
        rst_n_q  <= rst_n_d;
        busy_q   <= busy_d;
`ifdef CHIMERA_ISO_TIMEOUT_EN
        hs_q     <= hs_d;
        to_q     <= to_d;
`endif
      end
    end

    assign isolate_o[g]      = iso_q;
    assign clk_en_o[g]       = clk_en_q;
    assign cluster_rst_no[g] = rst_n_q;
    assign busy_o[g]         = busy_q;
`ifdef CHIMERA_ISO_TIMEOUT_EN
    assign timeout_o[g]      = to_q;
`else
    assign timeout_o[g]      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_chimera_clu_iso_ctrl.sv
module tb_chimera_clu_iso_ctrl;

  localparam int NC = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NC-1:0] power_down_req_i, reset_req_i, isolated_i;
  logic [NC-1:0] isolate_o, clk_en_o, cluster_rst_no, busy_o, timeout_o;

  chimera_clu_iso_ctrl #(.NumClusters(NC), .RstHoldCycles(16), .TimeoutCycles(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .power_down_req_i(power_down_req_i), .reset_req_i(reset_req_i), .isolated_i(isolated_i),
    .isolate_o(isolate_o), .clk_en_o(clk_en_o), .cluster_rst_no(cluster_rst_no),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NC-1:0] iso, clk, rst, busy, to;
  } outs_t;

  // Per-state output pattern: {isolate, clk_en, rst_n, busy}.
  localparam logic [3:0] S_RUN  = 4'b0110;
  localparam logic [3:0] S_IREQ = 4'b1111;
  localparam logic [3:0] S_ISOL = 4'b1011;
  localparam logic [3:0] S_HOLD = 4'b1101;
  localparam logic [3:0] S_REL  = 4'b0111;

  typedef struct {
    int         cl;
    logic       pdr, rr, iso;
    int         n;
    logic [3:0] st;
    string      name;
  } vec_t;

  vec_t  tbl[$];
  outs_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic outs_t mk(int cl, logic [3:0] st, logic [NC-1:0] to);
    outs_t o;
    o.iso  = '0;
    o.clk  = '1;
    o.rst  = '1;
    o.busy = '0;
    o.to   = to;
    o.iso[cl]  = st[3];
    o.clk[cl]  = st[2];
    o.rst[cl]  = st[1];
    o.busy[cl] = st[0];
    return o;
  endfunction

  function automatic outs_t rst_vals();
    outs_t o;
    o.iso  = '0;
    o.clk  = '1;
    o.rst  = '0;
    o.busy = '0;
    o.to   = '0;
    return o;
  endfunction

  task automatic chk(string name, outs_t e);
    outs_t a;
    a = {isolate_o, clk_en_o, cluster_rst_no, busy_o, timeout_o};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got iso=%b clk_en=%b rst_n=%b busy=%b to=%b, want iso=%b clk_en=%b rst_n=%b busy=%b to=%b",
               name, a.iso, a.clk, a.rst, a.busy, a.to, e.iso, e.clk, e.rst, e.busy, e.to);
    end
  endtask

  // Scoreboard step: queue the expectation, clock once, then compare at the falling edge.
  task automatic step(string name, outs_t e);
    outs_t got_e;
    exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    got_e = exp_q.pop_front();
    chk(name, got_e);
  endtask

  task automatic drive(int cl, logic pdr, logic rr, logic iso);
    power_down_req_i     = '0;
    reset_req_i          = '0;
    isolated_i           = '0;
    power_down_req_i[cl] = pdr;
    reset_req_i[cl]      = rr;
    isolated_i[cl]       = iso;
  endtask

  function automatic void add(int cl, logic pdr, logic rr, logic iso, int n, logic [3:0] st, string name);
    vec_t v;
    v.cl = cl; v.pdr = pdr; v.rr = rr; v.iso = iso; v.n = n; v.st = st; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    rst_i            = 1'b1;
    power_down_req_i = '0;
    reset_req_i      = '0;
    isolated_i       = '0;

    // Cluster 2: reset cycle. The ack comes 4 cycles after isolate. A reset pulse during RST_HOLD is ignored.
    add(2, 0, 1, 0,  1, S_IREQ, "c2_iso_req");
    add(2, 0, 0, 0,  3, S_IREQ, "c2_wait_ack");
    add(2, 0, 0, 1,  1, S_ISOL, "c2_isolated");
    add(2, 0, 0, 1,  8, S_HOLD, "c2_hold_a");
    add(2, 0, 1, 1,  1, S_HOLD, "c2_hold_rr_ignored");
    add(2, 0, 0, 1,  7, S_HOLD, "c2_hold_b");
    add(2, 0, 0, 1,  2, S_REL,  "c2_release_wait");
    add(2, 0, 0, 0,  1, S_RUN,  "c2_run");
    add(2, 0, 0, 0,  2, S_RUN,  "c2_no_retrigger");
    // Cluster 0: power-down held for 100 cycles, then released.
    add(0, 1, 0, 0,  1, S_IREQ, "c0_iso_req");
    add(0, 1, 0, 0,  3, S_IREQ, "c0_wait_ack");
    add(0, 1, 0, 1,  1, S_ISOL, "c0_clk_gated");
    add(0, 1, 0, 1, 95, S_ISOL, "c0_stay_isolated");
    add(0, 0, 0, 1, 16, S_HOLD, "c0_hold");
    add(0, 0, 0, 1,  1, S_REL,  "c0_release");
    add(0, 0, 0, 0,  1, S_RUN,  "c0_run");
    // Cluster 1: a reset pulse while ISOLATED under power-down goes straight to RST_HOLD.
    add(1, 1, 0, 0,  1, S_IREQ, "c1_iso_req");
    add(1, 1, 0, 1,  1, S_ISOL, "c1_isolated");
    add(1, 1, 0, 1,  3, S_ISOL, "c1_stay");
    add(1, 1, 1, 1,  1, S_HOLD, "c1_rr_to_hold");
    add(1, 1, 0, 1, 15, S_HOLD, "c1_hold");
    add(1, 0, 0, 1,  1, S_REL,  "c1_release");
    add(1, 0, 0, 0,  1, S_RUN,  "c1_run");
    // Cluster 4: power-down dropped during ISO_REQ still completes the full cycle.
    add(4, 1, 0, 0,  1, S_IREQ, "c4_iso_req");
    add(4, 0, 0, 0,  3, S_IREQ, "c4_no_abort");
    add(4, 0, 0, 1,  1, S_ISOL, "c4_isolated");
    add(4, 0, 0, 1, 16, S_HOLD, "c4_hold");
    add(4, 0, 0, 1,  1, S_REL,  "c4_release");
    add(4, 0, 0, 0,  1, S_RUN,  "c4_run");
    // Cluster 3: isolated_i is ignored in RUN.
    add(3, 0, 0, 1,  2, S_RUN,  "c3_ack_ignored");

    // Reset sequence.
    repeat (3) begin
      @(negedge clk_i);
      chk("reset_values", rst_vals());
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_run", mk(0, S_RUN, '0));

    // Table-driven sequences.
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].cl, tbl[i].pdr, (k == 0) ? tbl[i].rr : 1'b0, tbl[i].iso);
        step(tbl[i].name, mk(tbl[i].cl, tbl[i].st, '0));
      end
    end

    // Mid-sequence reset: abort cluster 2 while it is in RST_HOLD.
    drive(2, 0, 1, 0);
    step("mr_iso_req", mk(2, S_IREQ, '0));
    drive(2, 0, 0, 1);
    step("mr_isolated", mk(2, S_ISOL, '0));
    step("mr_hold", mk(2, S_HOLD, '0));
    step("mr_hold2", mk(2, S_HOLD, '0));
    #2 rst_i = 1'b1;
    #1 chk("mr_async_reset", rst_vals());
    @(negedge clk_i);
    chk("mr_reset_held", rst_vals());
    rst_i = 1'b0;
    drive(2, 0, 0, 0);
    @(negedge clk_i);
    chk("mr_run_after", mk(2, S_RUN, '0));
    step("mr_no_resume", mk(2, S_RUN, '0));

    // Timeout handling on cluster 3: the acknowledge never comes.
`ifdef CHIMERA_ISO_TIMEOUT_EN
    for (int k = 1; k <= 1025; k++) begin
      drive(3, 1, 0, 0);
      if (k <= 1024) step("to_iso_req", mk(3, S_IREQ, '0));
      else           step("to_isolated", mk(3, S_ISOL, 5'b01000));
    end
    drive(3, 1, 0, 0);
    step("to_sticky", mk(3, S_ISOL, 5'b01000));
    drive(3, 0, 0, 0);
    step("to_sticky_hold", mk(3, S_HOLD, 5'b01000));
`else
    for (int k = 1; k <= 5000; k++) begin
      drive(3, 1, 0, 0);
      step("no_to_wait", mk(3, S_IREQ, '0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chimera_clu_iso_ctrl.md
CHIMERA_CLU_ISO_CTRL -- requirements
Module: chimera_clu_iso_ctrl

Interface
REQ-001 SHALL have parameter NumClusters, default 5, number of independently sequenced clusters.
REQ-002 SHALL have parameter RstHoldCycles, default 16, cluster reset assertion length in cycles (range 1..255).
REQ-003 SHALL have parameter TimeoutCycles, default 1024, isolate/de-isolate handshake timeout in cycles (range 2..65535).
REQ-004 SHALL have port clk_i  in  1  SoC clock; the block uses one clock, and every register is clocked on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port power_down_req_i  in  NumClusters  level request to isolate and clock-gate cluster i.
REQ-007 SHALL have port reset_req_i  in  NumClusters  single-cycle pulse requesting an isolate-reset-release cycle for cluster i.
REQ-008 SHALL have port isolated_i  in  NumClusters  isolation acknowledge from the cluster domain isolate output.
REQ-009 SHALL have port isolate_o  out  NumClusters  isolation request to the cluster domain isolate input.
REQ-010 SHALL have port clk_en_o  out  NumClusters  cluster clock enable.
REQ-011 SHALL have port cluster_rst_no  out  NumClusters  cluster reset, active-low.
REQ-012 SHALL have port busy_o  out  NumClusters  high whenever the cluster i FSM is not in RUN.
REQ-013 SHALL have port timeout_o  out  NumClusters  sticky handshake timeout flag.

Function
REQ-014 SHALL instantiate one independent FSM per cluster, with states RUN, ISO_REQ, ISOLATED, RST_HOLD and RELEASE; no state is shared between clusters.
REQ-015 All outputs SHALL be registered, and decoded from state on the cycle after the transition.
- RUN: isolate=0, clk_en=1, rst_n=1.
- ISO_REQ: isolate=1, clk_en=1, rst_n=1.
- ISOLATED: isolate=1, clk_en=0, rst_n=1.
- RST_HOLD: isolate=1, clk_en=1, rst_n=0.
- RELEASE: isolate=0, clk_en=1, rst_n=1.
REQ-016 RUN transitions:
- to ISO_REQ when power_down_req_i=1 or reset_req_i=1;
- when reset_req_i=1, the pending-reset flag SHALL be set.
REQ-017 ISO_REQ SHALL go to ISOLATED on the first cycle with isolated_i=1.
REQ-018 ISOLATED SHALL go to RST_HOLD when the pending-reset flag is set or power_down_req_i=0; otherwise it SHALL remain in ISOLATED.
REQ-019 On entering RST_HOLD, the pending-reset flag SHALL be cleared.
REQ-020 RST_HOLD SHALL hold for exactly RstHoldCycles cycles using a counter loaded on entry, then go to RELEASE.
REQ-021 RELEASE SHALL go to RUN on the first cycle with isolated_i=0.
REQ-022 reset_req_i SHALL be latched into the pending-reset flag in RUN, ISO_REQ and ISOLATED, and ignored in RST_HOLD and RELEASE.
REQ-023 power_down_req_i deasserting during ISO_REQ SHALL NOT abort the sequence; the cluster completes the full isolate, reset and release cycle.
REQ-024 isolated_i SHALL be sampled only in ISO_REQ and RELEASE; its value in other states SHALL have no effect.
REQ-025 Handshake counter: 16-bit, cleared on entry to ISO_REQ and RELEASE, and incremented on every cycle the FSM waits in those states.

Reset
REQ-026 While rst_i=1, for every cluster:
- FSM = RUN; counters = 0; pending flag = 0;
- isolate_o=0, clk_en_o=1, cluster_rst_no=0, busy_o=0, timeout_o=0.
REQ-027 On the first rising clk_i edge after rst_i deasserts, cluster_rst_no SHALL go to 1.
REQ-028 rst_i asserted mid-sequence SHALL abort all FSMs immediately (asynchronously) to the reset values, with no completion of the in-flight handshake.

Configuration
REQ-029 Macro CHIMERA_ISO_TIMEOUT_EN, when defined, SHALL enable the timeout feature:
- when the handshake counter reaches TimeoutCycles-1 in ISO_REQ, the FSM SHALL go to ISOLATED;
- when it reaches TimeoutCycles-1 in RELEASE, the FSM SHALL go to RUN;
- in both cases timeout_o[i] SHALL be set and SHALL remain set until rst_i.
REQ-030 When CHIMERA_ISO_TIMEOUT_EN is undefined, ISO_REQ and RELEASE SHALL wait indefinitely, timeout_o SHALL be tied 0, and no timeout counter logic SHALL be synthesized.

Verification
REQ-031 Reset sequence: hold rst_i=1 for 3 cycles, then release -> all outputs equal the REQ-026 values during reset, and cluster_rst_no=1 after the first clk_i edge.
REQ-032 Reset cycle on cluster 2: pulse reset_req_i[2]; isolated_i[2] rises 4 cycles after isolate_o[2] -> states pass ISO_REQ, ISOLATED, RST_HOLD for 16 cycles, then RELEASE -> RUN once isolated_i[2]=0; clusters 0, 1, 3 and 4 are unaffected.
REQ-033 Power-down on cluster 0: hold power_down_req_i[0]=1 for 100 cycles -> clk_en_o[0]=0 from the cycle after isolated_i[0] rises; deasserting the request -> 16-cycle reset, then RUN.
REQ-034 Simultaneous events: reset_req_i[1] pulsed while cluster 1 is in ISOLATED under power_down_req_i[1]=1 -> RST_HOLD is entered on the next cycle.
REQ-035 Timeout with CHIMERA_ISO_TIMEOUT_EN defined: isolated_i[3] held at 0 -> ISOLATED after 1024 cycles, and timeout_o[3]=1 and sticky. With the macro undefined -> the FSM stays in ISO_REQ for 5000 cycles.
REQ-036 Mid-sequence reset: assert rst_i during RST_HOLD -> outputs take the REQ-026 values asynchronously, within the same cycle.
